// File: rtl/aes_key_schedule_iter.sv
// aes_key_schedule_iter
// Iterative AES-128/192/256 key schedule. Produces one 32-bit schedule word
// per clock through a single shared SubWord path and keeps the whole schedule
// in an internal word array that is read back one round key at a time.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   key_in      cipher key, MSB-aligned (w0 = key_in[255:224])
//   key_valid   load request, accepted while key_ready is high
//   key_ready   high while idle
//   busy        high while the schedule is being expanded
//   done        one-cycle pulse after the last word is written
//   keys_valid  schedule complete and untouched since
//   rk_idx      round-key index for the read port
//   rk_out      registered round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}

// AES S-box: multiplicative inverse in GF(2^8) via x^254, then affine map.
module sub_box (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x3, x7, x15, x31, x63, x127, inv;

  // Addition chain 1,3,7,15,...,127,254; zero maps to zero naturally.
  assign x3   = gf_mul(gf_mul(in_i, in_i), in_i);
  assign x7   = gf_mul(gf_mul(x3, x3), in_i);
  assign x15  = gf_mul(gf_mul(x7, x7), in_i);
  assign x31  = gf_mul(gf_mul(x15, x15), in_i);
  assign x63  = gf_mul(gf_mul(x31, x31), in_i);
  assign x127 = gf_mul(gf_mul(x63, x63), in_i);
  assign inv  = gf_mul(x127, x127);

  assign out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                 {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

module aes_key_schedule_iter #(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int IW = 6;

  localparam logic [IW-1:0] NK_W     = IW'(NK);
  localparam logic [IW-1:0] LAST_W   = IW'(NW - 1);
  localparam logic [2:0]    MOD_LAST = 3'(NK - 1);
  localparam logic [3:0]    NR_IDX   = 4'(NR);

  generate
    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
      $error("aes_key_schedule_iter: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t         state_q;
  logic [IW-1:0]  i_q, i_d;
  logic [2:0]     mod_q, mod_d;        // i mod NK without a divider
  logic [7:0]     rcon_q, rcon_d;
  logic           done_q;
  logic           keys_valid_q;
  logic [127:0]   rk_out_q, rk_out_d;
  logic [31:0]    w_q [NW];

  logic           accept;
  logic [31:0]    prev_w, back_w, rot_w, sub_in, sub_out, t_w, new_w;

  // Whole key bus is observed so narrower keys leave no dangling bits.
  logic           unused_key_bits;
  assign unused_key_bits = ^key_in;

  assign accept = (state_q == IDLE) && key_valid;
  assign prev_w = w_q[i_q - 6'd1];
  assign back_w = w_q[i_q - NK_W];
  assign rot_w  = {prev_w[23:0], prev_w[31:24]};
  assign sub_in = (mod_q == 3'd0) ? rot_w : prev_w;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      sub_box u_sub_box (
        .in_i  (sub_in[8*gi +: 8]),
        .out_o (sub_out[8*gi +: 8])
      );
    end
  endgenerate

  always_comb begin
    t_w = prev_w;
    if (mod_q == 3'd0) begin
      t_w = sub_out ^ {rcon_q, 24'h0};
    end else if (NK == 8 && mod_q == 3'd4) begin
      t_w = sub_out;
    end
    new_w  = back_w ^ t_w;
    i_d    = i_q + 6'd1;
    mod_d  = (mod_q == MOD_LAST) ? 3'd0 : mod_q + 3'd1;
    rcon_d = (mod_q == 3'd0) ? ({rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00)) : rcon_q;
  end

  // Read port: out-of-range indices are clamped for addressing and zeroed.
  logic [3:0]    rk_sel;
  logic [IW-1:0] rk_base;
  logic [31:0]   rk_word [4];

  assign rk_sel  = (rk_idx > NR_IDX) ? 4'd0 : rk_idx;
  assign rk_base = {rk_sel, 2'b00};

  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd
      assign rk_word[gi] = w_q[rk_base + IW'(gi)];
    end
  endgenerate

  assign rk_out_d = (rk_idx > NR_IDX) ? 128'h0 :
                    {rk_word[0], rk_word[1], rk_word[2], rk_word[3]};

  // Schedule storage: no reset, validity is tracked by keys_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NK; k++) begin
        w_q[k] <= key_in[255-32*k -: 32];
      end
    end else if (state_q == EXPAND) begin
      w_q[i_q] <= new_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      i_q          <= '0;
      mod_q        <= 3'd0;
      rcon_q       <= 8'h01;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rk_out_q     <= 128'h0;
    end else begin
      rk_out_q <= rk_out_d;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            state_q      <= EXPAND;
            i_q          <= NK_W;
            mod_q        <= 3'd0;
            rcon_q       <= 8'h01;
            keys_valid_q <= 1'b0;
          end
        end
        EXPAND: begin
          i_q    <= i_d;
          mod_q  <= mod_d;
          rcon_q <= rcon_d;
          if (i_q == LAST_W) begin
            state_q      <= IDLE;
            done_q       <= 1'b1;
            keys_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_ready  = (state_q == IDLE);
  assign busy       = (state_q == EXPAND);
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rk_out     = rk_out_q;

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
module tb_aes_key_schedule_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [255:0] key_a, key_b, key_c;
  logic         kv_a, kv_b, kv_c;
  logic         kr_a, kr_b, kr_c;
  logic         busy_a, busy_b, busy_c;
  logic         done_a, done_b, done_c;
  logic         kval_a, kval_b, kval_c;
  logic [3:0]   idx_a, idx_b, idx_c;
  logic [127:0] out_a, out_b, out_c;

  aes_key_schedule_iter #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst_n(rst_n), .key_in(key_a), .key_valid(kv_a), .key_ready(kr_a),
    .busy(busy_a), .done(done_a), .keys_valid(kval_a), .rk_idx(idx_a), .rk_out(out_a));
  aes_key_schedule_iter #(.KEY_BITS(192)) u192 (
    .clk(clk), .rst_n(rst_n), .key_in(key_b), .key_valid(kv_b), .key_ready(kr_b),
    .busy(busy_b), .done(done_b), .keys_valid(kval_b), .rk_idx(idx_b), .rk_out(out_b));
  aes_key_schedule_iter #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst_n(rst_n), .key_in(key_c), .key_valid(kv_c), .key_ready(kr_c),
    .busy(busy_c), .done(done_c), .keys_valid(kval_c), .rk_idx(idx_c), .rk_out(out_c));

  localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] RK14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  int checks = 0;
  int failures = 0;

  // Independent software model: log/antilog S-box and plain key expansion.
  logic [7:0]  exp_t [0:255];
  logic [7:0]  log_t [0:255];
  logic [31:0] wm [0:43];

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] a);
    logic [7:0] b, s, c;
    int li;
    c = 8'h63;
    if (a == 8'h00) b = 8'h00;
    else begin
      li = (255 - int'(log_t[a])) % 255;
      b = exp_t[li];
    end
    for (int k = 0; k < 8; k++) begin
      s[k] = b[k] ^ b[(k+4)%8] ^ b[(k+5)%8] ^ b[(k+6)%8] ^ b[(k+7)%8] ^ c[k];
    end
    return s;
  endfunction

  task automatic build_tables();
    logic [7:0] e;
    e = 8'h01;
    for (int k = 0; k < 255; k++) begin
      exp_t[k] = e;
      log_t[e] = 8'(k);
      e = e ^ xt(e);
    end
    exp_t[255] = 8'h01;
    log_t[0] = 8'h00;
  endtask

  task automatic model128(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int j = 0; j < 4; j++) wm[j] = k[127-32*j -: 32];
    for (int j = 4; j < 44; j++) begin
      t = wm[j-1];
      if (j % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      wm[j] = wm[j-4] ^ t;
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int s);
    case (s)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  // Called one step after the accept edge; counts edges including it.
  task automatic wait_done(input int s, input int exp_edges, input string tag);
    int cnt;
    cnt = 1;
    while (!done_of(s) && cnt < 200) begin
      tick();
      cnt++;
    end
    chk(tag, 256'(cnt), 256'(exp_edges));
  endtask

  task automatic read_rk(input int s, input logic [3:0] idx, output logic [127:0] v);
    case (s)
      0:       idx_a = idx;
      1:       idx_b = idx;
      default: idx_c = idx;
    endcase
    tick();
    case (s)
      0:       v = out_a;
      1:       v = out_b;
      default: v = out_c;
    endcase
  endtask

  initial begin
    logic [127:0] v;
    int cnt;
    int kval_seen;

    rst_n = 1'b0;
    key_a = '0; key_b = '0; key_c = '0;
    kv_a = 1'b0; kv_b = 1'b0; kv_c = 1'b0;
    idx_a = 4'd0; idx_b = 4'd0; idx_c = 4'd0;
    build_tables();
    tick();
    tick();

    chk("rst_key_ready", 256'(kr_a), 256'(1'b1));
    chk("rst_busy", 256'(busy_a), 256'(1'b0));
    chk("rst_done", 256'(done_a), 256'(1'b0));
    chk("rst_keys_valid", 256'(kval_a), 256'(1'b0));
    chk("rst_rk_out", 256'(out_a), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // AES-128 single load, junk in the unused LSBs
    key_a = {K128, 128'hdeadbeef_cafef00d_12345678_9abcdef0};
    kv_a = 1'b1;
    tick();
    kv_a = 1'b0;
    chk("a128_busy_after_accept", 256'(busy_a), 256'(1'b1));
    chk("a128_ready_after_accept", 256'(kr_a), 256'(1'b0));
    wait_done(0, 41, "a128_done_latency");
    chk("a128_keys_valid_at_done", 256'(kval_a), 256'(1'b1));
    chk("a128_ready_at_done", 256'(kr_a), 256'(1'b1));
    $display("load aes128 key=%h done", K128);
    read_rk(0, 4'd0, v);
    chk("a128_rk0", 256'(v), 256'(K128));
    read_rk(0, 4'd10, v);
    chk("a128_rk10", 256'(v), 256'(RK10_128));
    read_rk(0, 4'd11, v);
    chk("a128_rk11_zero", 256'(v), 256'(0));
    chk("a128_done_pulse_dropped", 256'(done_a), 256'(1'b0));
    chk("a128_keys_valid_held", 256'(kval_a), 256'(1'b1));

    // Every schedule word against the model (covers rcon 80 -> 1b -> 36)
    model128(K128);
    for (int r = 0; r <= 10; r++) begin
      read_rk(0, 4'(r), v);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("a128_w%0d", 4*r+j), 256'(v[127-32*j -: 32]), 256'(wm[4*r+j]));
      end
    end

    // AES-192
    key_b = {K192, 64'hffff_ffff_ffff_ffff};
    kv_b = 1'b1;
    tick();
    kv_b = 1'b0;
    wait_done(1, 47, "a192_done_latency");
    $display("load aes192 key=%h done", K192);
    read_rk(1, 4'd12, v);
    chk("a192_rk12", 256'(v), 256'(RK12_192));
    read_rk(1, 4'd13, v);
    chk("a192_rk13_zero", 256'(v), 256'(0));

    // AES-256
    key_c = K256;
    kv_c = 1'b1;
    tick();
    kv_c = 1'b0;
    wait_done(2, 53, "a256_done_latency");
    $display("load aes256 key=%h done", K256);
    read_rk(2, 4'd14, v);
    chk("a256_rk14", 256'(v), 256'(RK14_256));
    read_rk(2, 4'd15, v);
    chk("a256_rk15_zero", 256'(v), 256'(0));

    // Backpressure: key_valid held with a different key during expansion
    key_a = {K128, 128'h0};
    kv_a = 1'b1;
    tick();
    key_a = {K128B, 128'h0};
    wait_done(0, 41, "bp_first_done_latency");
    chk("bp_keys_valid_at_done", 256'(kval_a), 256'(1'b1));
    idx_a = 4'd10;
    tick();
    kv_a = 1'b0;
    chk("bp_first_key_used", 256'(out_a), 256'(RK10_128));
    chk("bp_second_accepted_busy", 256'(busy_a), 256'(1'b1));
    chk("bp_keys_valid_cleared", 256'(kval_a), 256'(1'b0));
    chk("bp_done_dropped", 256'(done_a), 256'(1'b0));
    cnt = 1;
    kval_seen = 0;
    while (!done_a && cnt < 200) begin
      if (kval_a) kval_seen++;
      tick();
      cnt++;
    end
    chk("bp_second_done_latency", 256'(cnt), 256'(41));
    chk("bp_keys_valid_low_during_expand", 256'(kval_seen), 256'(0));
    $display("load aes128 key=%h done (held request)", K128B);
    model128(K128B);
    read_rk(0, 4'd10, v);
    chk("bp_second_rk10", 256'(v), 256'({wm[40], wm[41], wm[42], wm[43]}));
    read_rk(0, 4'd0, v);
    chk("bp_second_rk0", 256'(v), 256'(K128B));

    // Reset 20 cycles into an AES-128 expansion
    key_a = {K128, 128'h0};
    kv_a = 1'b1;
    tick();
    kv_a = 1'b0;
    idx_a = 4'd0;
    repeat (20) tick();
    chk("mid_busy_before_reset", 256'(busy_a), 256'(1'b1));
    chk("mid_rk_out_before_reset", 256'(out_a), 256'(K128));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_busy", 256'(busy_a), 256'(1'b0));
    chk("mid_reset_ready", 256'(kr_a), 256'(1'b1));
    chk("mid_reset_rk_out", 256'(out_a), 256'(0));
    #1;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_reset_keys_valid", 256'(kval_a), 256'(1'b0));
    chk("post_reset_busy", 256'(busy_a), 256'(1'b0));
    $display("reset during aes128 expansion");
    key_a = {K128, 128'h0};
    kv_a = 1'b1;
    tick();
    kv_a = 1'b0;
    wait_done(0, 41, "reload_done_latency");
    $display("reload aes128 key=%h done", K128);
    read_rk(0, 4'd10, v);
    chk("reload_rk10", 256'(v), 256'(RK10_128));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_iter.md
# aes_key_schedule_iter

Iterative, parametrised AES key schedule supporting AES-128/192/256. It generates one 32-bit schedule word per clock with a single shared SubWord path (four `sub_box` instances) and stores the full schedule internally. Round keys are read back through an indexed, registered read port. It sits between key load logic and iterative or pipelined round datapaths, replacing a fully unrolled 128-bit-only expansion.

## Interface
- KEY_BITS, 128: key length; legal values are 128, 192 and 256; any other value is a elaboration error.
- Derived, not overridable: NK = KEY_BITS/32 (4/6/8); NR = NK+6 (10/12/14); NW = 4*(NR+1) (44/52/60).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- key_in  in  256  cipher key. Uses bits [255:256-KEY_BITS]. Word w0 = key_in[255:224]. Unused LSBs are ignored.
- key_valid  in  1  load request.
- key_ready  out  1  high in IDLE only; a load is accepted when key_valid && key_ready at a rising edge.
- busy  out  1  high in EXPAND.
- done  out  1  one-cycle pulse when the last word is written.
- keys_valid  out  1  high from the done pulse until the next accepted load or reset.
- rk_idx  in  4  round-key index, 0..NR.
- rk_out  out  128  registered round key rk_idx, = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96].

## Operation
- States: IDLE, EXPAND.
- IDLE → EXPAND on accept. EXPAND → IDLE after word NW-1 is written; no other transitions.
- On accept:
  - w0..w(NK-1) are written from key_in in the same edge.
  - Counter i is set to NK, rcon to 0x01, and keys_valid is cleared.
- Each EXPAND cycle computes and writes w[i], then increments i:
  - t = w[i-1].
  - If i mod NK == 0: t = SubWord(RotWord(t)) ^ {rcon, 24'h0}. RotWord moves the byte in [31:24] to [7:0]. rcon then advances by xtime: rcon = (rcon<<1) ^ (rcon[7] ? 8'h1b : 0), giving 01,02,…,80,1b,36.
  - Else if NK == 8 and i mod 8 == 4: t = SubWord(t), with no rotation and no rcon.
  - w[i] = w[i-NK] ^ t.
- i mod NK must be tracked with a wrapping sub-counter (0..NK-1), not a divider.
- Storage is an NW×32 register array. It is not reset; contents are only meaningful when keys_valid = 1.
- Read port:
  - rk_out <= words 4*rk_idx..4*rk_idx+3 on every edge, in any state.
  - rk_idx > NR gives rk_out <= 0.
  - Reads during EXPAND return the current array contents; these are stale or partial, and keys_valid = 0 flags them.
- key_valid while key_ready = 0 is ignored and not queued. The requester must hold it.
- Reset values:
  - state IDLE, key_ready 1, busy 0, done 0, keys_valid 0, rk_out 0.
  - i = 0, rcon 0x01.
- Reset asserted mid-EXPAND aborts immediately. keys_valid stays 0 after release, and a new load is required.

## Timing
- Edge E0: load accepted; w0..w(NK-1) written; busy = 1 and key_ready = 0 after E0.
- Edges E1..E(NW-NK): one word each. That is 40 cycles for AES-128, 46 for AES-192, 52 for AES-256.
- done = 1 and keys_valid = 1 during the cycle following edge E(NW-NK). In that same cycle state is IDLE and key_ready = 1.
- A new load can therefore be accepted at edge E(NW-NK)+1. At that edge done drops and keys_valid clears.
- Load-to-done latency: NW-NK+1 edges counting E0.
- rk_out latency: 1 cycle from rk_idx.
- The critical path is w[i-1] → SubWord → XORs → array write. There is no multi-cycle path.

## Test plan
- KEY_BITS=128, key_in[255:128]=2b7e151628aed2a6abf7158809cf4f3c, one load:
  - done asserts exactly 41 edges after the accept edge.
  - rk_idx=0 → rk_out = 2b7e151628aed2a6abf7158809cf4f3c.
  - rk_idx=10 → rk_out = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_idx=11 → rk_out = 0.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done 47 edges after accept.
  - rk_idx=12 → e98ba06f448c773c8ecc720401002202, which exercises the mid-round-key rcon/rotation alignment.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done 53 edges after accept.
  - rk_idx=14 → fe4890d1e6188d0b046df344706c631e, which proves the i mod 8 == 4 SubWord.
- Backpressure:
  - key_valid held high through EXPAND with a different key_in → only the first key is used.
  - The second key is accepted on the first edge after done. keys_valid goes 1 for exactly one cycle, then 0 through the second expansion.
- Reset mid-operation (AES-128):
  - Assert rst_n=0 asynchronously 20 cycles into EXPAND → busy 0, key_ready 1 and rk_out 0 immediately, without waiting for a clock edge.
  - After release, keys_valid remains 0 with no load.
  - A reload of the same key → rk_idx=10 matches d014f9a8….
- Rcon wrap (AES-128): check w36 = 4d1bf9e9? No — compare every w[i], i=4..43, against a software model. This verifies the 80→1b→36 transition at rounds 8–10.
